// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vending transaction controller.
//   state_t      - transaction FSM states
//   COIN_*       - 2-bit coin codes (coin_type / change_type encoding)
//   VAL_*        - coin values in credit units
//   coin_value() - code-to-value map, shared by acceptance and change paths
package vend_pkg;

    localparam int unsigned COIN_VW = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRICE    = 3'd1,
        ST_COLLECT  = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } state_t;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;
    localparam logic [1:0] COIN_25 = 2'b11;

    localparam logic [COIN_VW-1:0] VAL_1  = 5'd1;
    localparam logic [COIN_VW-1:0] VAL_5  = 5'd5;
    localparam logic [COIN_VW-1:0] VAL_10 = 5'd10;
    localparam logic [COIN_VW-1:0] VAL_25 = 5'd25;

    function automatic logic [COIN_VW-1:0] coin_value(input logic [1:0] code);
        logic [COIN_VW-1:0] v;
        case (code)
            COIN_1:  v = VAL_1;
            COIN_5:  v = VAL_5;
            COIN_10: v = VAL_10;
            default: v = VAL_25;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_txn_ctrl_change_coin_sel.sv
// Largest-coin encoder: returns the code of the biggest coin not exceeding
// amount. Used for both refunds and change.
//   amount  in  CW  credit to be returned
//   code_c  out 2   coin code (combinational)
module change_coin_sel
    import vend_pkg::*;
#(
    parameter int unsigned CW = 7
) (
    input  logic [CW-1:0] amount,
    output logic [1:0]    code_c
);

    always_comb begin
        code_c = COIN_1;
        if (amount >= CW'(VAL_25))      code_c = COIN_25;
        else if (amount >= CW'(VAL_10)) code_c = COIN_10;
        else if (amount >= CW'(VAL_5))  code_c = COIN_5;
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller sitting downstream of the 8-way price mux.
// Registers the item selection (drives mux_sel), samples the returned price,
// accumulates coin credit, issues a one-cycle vend and pays out change or a
// refund one coin at a time, largest first.
//   clk, rst_n            clock, async active-low reset
//   sel_valid, item_sel   item selection (IDLE only)
//   mux_sel, price        price mux select out / price in (0 = sold out)
//   coin_valid, coin_type coin insertion strobe and code
//   cancel                refund request (COLLECT only)
//   change_ready          dispenser handshake
//   coin_reject           coin not credited (pulse, one cycle after the coin)
//   sel_error             sold-out pulse, decoded in PRICE from the mux loop
//   vend, vend_item       dispense command and item
//   change_valid/_type    change coin offer
//   credit                current credit
//   busy                  not IDLE
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = 99,
    parameter int unsigned CW         = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sel_valid,
    input  logic [2:0]    item_sel,
    output logic [2:0]    mux_sel,
    input  logic [5:0]    price,
    input  logic          coin_valid,
    input  logic [1:0]    coin_type,
    input  logic          cancel,
    input  logic          change_ready,
    output logic          coin_reject,
    output logic          sel_error,
    output logic          vend,
    output logic [2:0]    vend_item,
    output logic          change_valid,
    output logic [1:0]    change_type,
    output logic [CW-1:0] credit,
    output logic          busy
);

    localparam int unsigned SW = CW + 1;

    state_t        state, state_d;
    logic [5:0]    price_q, price_d;
    logic [2:0]    mux_sel_d;
    logic [CW-1:0] credit_d;
    logic          coin_reject_d;
    logic          vend_d;
    logic [2:0]    vend_item_d;
    logic          change_valid_d;
    logic [1:0]    change_type_d;
    logic          busy_d;

    logic          coin_open;
    logic [SW-1:0] coin_sum;
    logic [CW-1:0] change_val;

    // One extra bit on the sum so the overflow guard is exact.
    assign coin_sum   = {1'b0, credit} + SW'(coin_value(coin_type));
    assign change_val = CW'(coin_value(change_type));
    assign coin_open  = (state == ST_IDLE) || ((state == ST_COLLECT) && !cancel);

    // Sold-out is flagged in the same cycle the mux returns the price.
    assign sel_error  = (state == ST_PRICE) && (price == 6'd0);

    // Change code follows next-cycle credit so it is registered alongside it.
    change_coin_sel #(.CW(CW)) u_change_sel (
        .amount (credit_d),
        .code_c (change_type_d)
    );

    // Next-state, credit and output decode.
    always_comb begin
        state_d       = state;
        price_d       = price_q;
        mux_sel_d     = mux_sel;
        credit_d      = credit;
        coin_reject_d = 1'b0;
        vend_d        = 1'b0;
        vend_item_d   = 3'd0;

        // Coin acceptance; anything not credited is rejected.
        if (coin_valid) begin
            if (coin_open && (coin_sum <= SW'(MAX_CREDIT))) begin
                credit_d = coin_sum[CW-1:0];
            end else begin
                coin_reject_d = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    mux_sel_d = item_sel;
                    state_d   = ST_PRICE;
                end
            end
            ST_PRICE: begin
                price_d = price;
                state_d = (price == 6'd0) ? ST_IDLE : ST_COLLECT;
            end
            ST_COLLECT: begin
                if (cancel) begin
                    state_d = (credit == '0) ? ST_IDLE : ST_CHANGE;
                end else if (credit >= CW'(price_q)) begin
                    state_d     = ST_DISPENSE;
                    vend_d      = 1'b1;
                    vend_item_d = mux_sel;
                end
            end
            ST_DISPENSE: begin
                credit_d = credit - CW'(price_q);
                state_d  = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (change_valid && change_ready) begin
                    credit_d = credit - change_val;
                end
                if (credit_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        change_valid_d = (state_d == ST_CHANGE) && (credit_d != '0);
        busy_d         = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            price_q      <= 6'd0;
            mux_sel      <= 3'd0;
            credit       <= '0;
            coin_reject  <= 1'b0;
            vend         <= 1'b0;
            vend_item    <= 3'd0;
            change_valid <= 1'b0;
            change_type  <= 2'b00;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            price_q      <= price_d;
            mux_sel      <= mux_sel_d;
            credit       <= credit_d;
            coin_reject  <= coin_reject_d;
            vend         <= vend_d;
            vend_item    <= vend_item_d;
            change_valid <= change_valid_d;
            change_type  <= change_type_d;
            busy         <= busy_d;
        end
    end

endmodule
